// File: rtl/harris_response_pipe.sv
// ----------------------------------------------------------------------------
// harris_response_pipe
//
// Streaming Harris corner-response unit. Each handshake delivers one
// P_WIN-tall column of signed gradient pairs (Ix, Iy); a sliding
// P_WIN x P_WIN window is maintained internally and, once a row has supplied
// P_WIN columns, every further column yields
//    R = det(M) - (trace(M)^2 >>> P_K_SHIFT)
// saturated to a signed P_OUT_W result.
//
// Pipeline (all stages advance together on adv = !out_valid || out_ready):
//    S1  column sums cA = sum Ix^2, cB = sum Ix*Iy, cC = sum Iy^2
//    S2  window sums A/B/C = sum + new - oldest (circular column history)
//    S3  det = A*C - B*B, tr2 = (A+C)^2
//    S4  R = det - (tr2 >>> P_K_SHIFT), saturated, registered to the output
//
// Ports:
//    clk         clock
//    reset_n     asynchronous active-low reset
//    in_valid    column valid
//    in_ready    column accepted when in_valid && in_ready
//    line_start  accepted column is first of a new row (restarts window fill)
//    in_ix       packed signed Ix column, row 0 in LSBs
//    in_iy       packed signed Iy column, row 0 in LSBs
//    out_valid   response valid
//    out_ready   downstream accepts when out_valid && out_ready
//    out_resp    signed saturated Harris response
//
// Optional build macro HARRIS_THRESH_EN adds:
//    thresh      signed threshold (P_OUT_W)
//    is_corner   registered (out_resp > thresh), held with out_resp
// ----------------------------------------------------------------------------
module harris_response_pipe #(
   parameter int P_NUM_BITS_IN = 4,
   parameter int P_WIN         = 3,
   parameter int P_K_SHIFT     = 4,
   parameter int P_OUT_W       = 16
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             line_start,
   input  logic [P_WIN*P_NUM_BITS_IN-1:0]   in_ix,
   input  logic [P_WIN*P_NUM_BITS_IN-1:0]   in_iy,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [P_OUT_W-1:0]               out_resp
`ifdef HARRIS_THRESH_EN
   ,
   input  logic [P_OUT_W-1:0]               thresh,
   output logic                             is_corner
`endif
);

   localparam int LP_N  = P_NUM_BITS_IN;
   localparam int LP_LW = $clog2(P_WIN);
   localparam int LP_CW = 2*LP_N + LP_LW;          // column-sum width
   localparam int LP_WW = 2*LP_N + 2*LP_LW;        // window-sum width
   localparam int LP_DW = 2*LP_WW + 2;             // det / tr2 / R width
   localparam int LP_FW = $clog2(P_WIN+1);         // fill counter width

   localparam logic signed [LP_DW-1:0] LP_MAX =
      LP_DW'((64'sd1 <<< (P_OUT_W-1)) - 64'sd1);
   localparam logic signed [LP_DW-1:0] LP_MIN =
      LP_DW'(-(64'sd1 <<< (P_OUT_W-1)));

   // ---------------------------------------------------------------------
   // Flow control
   // ---------------------------------------------------------------------
   logic w_adv;
   logic w_accept;
   logic r_out_valid;

   assign w_adv    = !r_out_valid || out_ready;
   assign w_accept = in_valid && w_adv;
   assign in_ready = w_adv;

   // ---------------------------------------------------------------------
   // S1: per-row products (sign-extended to column width first so the
   // products and their sum are exact), then column sums.
   // ---------------------------------------------------------------------
   logic signed [LP_CW-1:0] w_ix_e [P_WIN];
   logic signed [LP_CW-1:0] w_iy_e [P_WIN];
   logic signed [LP_CW-1:0] w_pxx  [P_WIN];
   logic signed [LP_CW-1:0] w_pxy  [P_WIN];
   logic signed [LP_CW-1:0] w_pyy  [P_WIN];

   genvar gi;
   generate
      for (gi = 0; gi < P_WIN; gi++) begin : g_row
         assign w_ix_e[gi] = LP_CW'($signed(in_ix[gi*LP_N +: LP_N]));
         assign w_iy_e[gi] = LP_CW'($signed(in_iy[gi*LP_N +: LP_N]));
         assign w_pxx[gi]  = w_ix_e[gi] * w_ix_e[gi];
         assign w_pxy[gi]  = w_ix_e[gi] * w_iy_e[gi];
         assign w_pyy[gi]  = w_iy_e[gi] * w_iy_e[gi];
      end
   endgenerate

   logic signed [LP_CW-1:0] w_ca;
   logic signed [LP_CW-1:0] w_cb;
   logic signed [LP_CW-1:0] w_cc;

   always_comb begin
      w_ca = '0;
      w_cb = '0;
      w_cc = '0;
      for (int r = 0; r < P_WIN; r++) begin
         w_ca = w_ca + w_pxx[r];
         w_cb = w_cb + w_pxy[r];
         w_cc = w_cc + w_pyy[r];
      end
   end

   // Fill counter: line_start restarts at 1, otherwise saturate at P_WIN.
   logic [LP_FW-1:0] r_fill_cnt;
   logic [LP_FW-1:0] w_fill_next;

   always_comb begin
      if (line_start)
         w_fill_next = LP_FW'(1);
      else if (r_fill_cnt == LP_FW'(P_WIN))
         w_fill_next = LP_FW'(P_WIN);
      else
         w_fill_next = r_fill_cnt + LP_FW'(1);
   end

   logic                    r_s1_valid;
   logic                    r_s1_full;
   logic                    r_s1_restart;
   logic signed [LP_CW-1:0] r_s1_ca;
   logic signed [LP_CW-1:0] r_s1_cb;
   logic signed [LP_CW-1:0] r_s1_cc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fill_cnt   <= '0;
         r_s1_valid   <= 1'b0;
         r_s1_full    <= 1'b0;
         r_s1_restart <= 1'b0;
         r_s1_ca      <= '0;
         r_s1_cb      <= '0;
         r_s1_cc      <= '0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_fill_cnt   <= w_fill_next;
            r_s1_full    <= (w_fill_next == LP_FW'(P_WIN));
            r_s1_restart <= line_start;
            r_s1_ca      <= w_ca;
            r_s1_cb      <= w_cb;
            r_s1_cc      <= w_cc;
         end
      end
   end

   // ---------------------------------------------------------------------
   // S2: sliding window sums. A restarting column sees an empty history
   // and zero sums, and is written into slot 0.
   // ---------------------------------------------------------------------
   logic signed [LP_CW-1:0] r_hist_a [P_WIN];
   logic signed [LP_CW-1:0] r_hist_b [P_WIN];
   logic signed [LP_CW-1:0] r_hist_c [P_WIN];
   logic        [LP_LW-1:0] r_ptr;
   logic signed [LP_WW-1:0] r_sum_a;
   logic signed [LP_WW-1:0] r_sum_b;
   logic signed [LP_WW-1:0] r_sum_c;
   logic                    r_s2_valid;

   logic        [LP_LW-1:0] w_wr_idx;
   logic        [LP_LW-1:0] w_ptr_next;
   logic signed [LP_WW-1:0] w_sum_a_next;
   logic signed [LP_WW-1:0] w_sum_b_next;
   logic signed [LP_WW-1:0] w_sum_c_next;

   always_comb begin
      w_wr_idx   = r_s1_restart ? '0 : r_ptr;
      w_ptr_next = (w_wr_idx == LP_LW'(P_WIN-1)) ? '0 : w_wr_idx + LP_LW'(1);
      if (r_s1_restart) begin
         w_sum_a_next = LP_WW'(r_s1_ca);
         w_sum_b_next = LP_WW'(r_s1_cb);
         w_sum_c_next = LP_WW'(r_s1_cc);
      end else begin
         w_sum_a_next = r_sum_a + LP_WW'(r_s1_ca) - LP_WW'(r_hist_a[r_ptr]);
         w_sum_b_next = r_sum_b + LP_WW'(r_s1_cb) - LP_WW'(r_hist_b[r_ptr]);
         w_sum_c_next = r_sum_c + LP_WW'(r_s1_cc) - LP_WW'(r_hist_c[r_ptr]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < P_WIN; k++) begin
            r_hist_a[k] <= '0;
            r_hist_b[k] <= '0;
            r_hist_c[k] <= '0;
         end
         r_ptr      <= '0;
         r_sum_a    <= '0;
         r_sum_b    <= '0;
         r_sum_c    <= '0;
         r_s2_valid <= 1'b0;
      end else if (w_adv) begin
         r_s2_valid <= r_s1_valid && r_s1_full;
         if (r_s1_valid) begin
            for (int k = 0; k < P_WIN; k++) begin
               if (LP_LW'(k) == w_wr_idx) begin
                  r_hist_a[k] <= r_s1_ca;
                  r_hist_b[k] <= r_s1_cb;
                  r_hist_c[k] <= r_s1_cc;
               end else if (r_s1_restart) begin
                  r_hist_a[k] <= '0;
                  r_hist_b[k] <= '0;
                  r_hist_c[k] <= '0;
               end
            end
            r_ptr   <= w_ptr_next;
            r_sum_a <= w_sum_a_next;
            r_sum_b <= w_sum_b_next;
            r_sum_c <= w_sum_c_next;
         end
      end
   end

   // ---------------------------------------------------------------------
   // S3: determinant and squared trace at full width.
   // ---------------------------------------------------------------------
   logic signed [LP_DW-1:0] w_a_e;
   logic signed [LP_DW-1:0] w_b_e;
   logic signed [LP_DW-1:0] w_c_e;
   logic signed [LP_DW-1:0] w_tr;
   logic signed [LP_DW-1:0] r_det;
   logic signed [LP_DW-1:0] r_tr2;
   logic                    r_s3_valid;

   assign w_a_e = LP_DW'(r_sum_a);
   assign w_b_e = LP_DW'(r_sum_b);
   assign w_c_e = LP_DW'(r_sum_c);
   assign w_tr  = w_a_e + w_c_e;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_det      <= '0;
         r_tr2      <= '0;
         r_s3_valid <= 1'b0;
      end else if (w_adv) begin
         r_s3_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_det <= w_a_e * w_c_e - w_b_e * w_b_e;
            r_tr2 <= w_tr * w_tr;
         end
      end
   end

   // ---------------------------------------------------------------------
   // S4: response, saturation, output register.
   // tr2 is a square, so the arithmetic shift is a plain floor divide.
   // ---------------------------------------------------------------------
   logic signed [LP_DW-1:0]   w_r;
   logic signed [P_OUT_W-1:0] w_sat;
   logic        [P_OUT_W-1:0] r_out_resp;

   assign w_r = r_det - (r_tr2 >>> P_K_SHIFT);

   always_comb begin
      if (w_r > LP_MAX)
         w_sat = {1'b0, {(P_OUT_W-1){1'b1}}};
      else if (w_r < LP_MIN)
         w_sat = {1'b1, {(P_OUT_W-1){1'b0}}};
      else
         w_sat = w_r[P_OUT_W-1:0];
   end

`ifdef HARRIS_THRESH_EN
   logic r_is_corner;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_is_corner <= 1'b0;
      else if (w_adv && r_s3_valid)
         r_is_corner <= (w_sat > $signed(thresh));
   end

   assign is_corner = r_is_corner;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_resp  <= '0;
      end else if (w_adv) begin
         r_out_valid <= r_s3_valid;
         if (r_s3_valid)
            r_out_resp <= w_sat;
      end
   end

   assign out_valid = r_out_valid;
   assign out_resp  = r_out_resp;

endmodule

// File: tb/tb_harris_response_pipe.sv
`timescale 1ns/1ps
module tb_harris_response_pipe;

   localparam int N   = 4;
   localparam int WIN = 3;
   localparam int OW  = 16;
   localparam int CW  = WIN*N;

   logic          clk        = 1'b0;
   logic          reset_n    = 1'b0;
   logic          in_valid   = 1'b0;
   logic          in_ready;
   logic          line_start = 1'b0;
   logic [CW-1:0] in_ix      = '0;
   logic [CW-1:0] in_iy      = '0;
   logic          out_valid;
   logic          out_ready  = 1'b1;
   logic [OW-1:0] out_resp;
`ifdef HARRIS_THRESH_EN
   logic [OW-1:0] thresh = 16'd100;
   logic          is_corner;
`endif

   always #5 clk = ~clk;

   harris_response_pipe #(
      .P_NUM_BITS_IN(N),
      .P_WIN(WIN),
      .P_K_SHIFT(4),
      .P_OUT_W(OW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .line_start(line_start),
      .in_ix(in_ix),
      .in_iy(in_iy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_resp(out_resp)
`ifdef HARRIS_THRESH_EN
      ,
      .thresh(thresh),
      .is_corner(is_corner)
`endif
   );

   int total = 0;
   int bad   = 0;
   int n_out = 0;
   logic [OW:0] exp_q[$];   // {is_corner, resp}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [CW-1:0] col3(input int a0, input int a1, input int a2);
      return {4'(a2), 4'(a1), 4'(a0)};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   logic          prev_stall = 1'b0;
   logic [OW-1:0] prev_resp  = '0;

   always @(negedge clk) begin
      logic [OW:0] e;
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_resp", {16'd0, out_resp}, {16'd0, prev_resp});
         end
         if (out_valid && out_ready) begin
            n_out++;
            $display("out resp=%0d", $signed(out_resp));
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output actual=%0h required=none", out_resp);
            end else begin
               e = exp_q.pop_front();
               check("resp", {16'd0, out_resp}, {16'd0, e[OW-1:0]});
`ifdef HARRIS_THRESH_EN
               check("is_corner", {31'd0, is_corner}, {31'd0, e[OW]});
`endif
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_resp  = out_resp;
      end
   end

   // ---------------- driver ----------------
   task automatic send_col(input logic [CW-1:0] ix, input logic [CW-1:0] iy, input logic ls,
                           input logic ev, input int er, input logic ec);
      bit done = 1'b0;
      @(negedge clk);
      in_valid   = 1'b1;
      in_ix      = ix;
      in_iy      = iy;
      line_start = ls;
      for (int t = 0; t < 100 && !done; t++) begin
         #2;
         if (in_ready) begin
            if (ev) exp_q.push_back({ec, 16'(er)});
            $display("in  ix=%h iy=%h ls=%0b expect=%0b/%0d", ix, iy, ls, ev, er);
            @(posedge clk);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL accept_timeout actual=stalled required=accepted");
      end
      #1;
      in_valid   = 1'b0;
      line_start = 1'b0;
   endtask

   // fresh row: line_start on the first column, result expected from column WIN-1 on
   task automatic send_row(input logic [CW-1:0] ix, input logic [CW-1:0] iy, input int ncol,
                           input int gap, input int er, input logic ec);
      for (int c = 0; c < ncol; c++) begin
         send_col(ix, iy, (c == 0), (c >= WIN-1), er, ec);
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      repeat (6) @(negedge clk);
   endtask

   logic [CW-1:0] ones_c, cor_ix, cor_iy;
   int base;

   initial begin
      ones_c = col3(1, 1, 1);
      cor_ix = col3(2, 0, 0);
      cor_iy = col3(0, 2, 0);

      // reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_resp", {16'd0, out_resp}, 32'd0);
`ifdef HARRIS_THRESH_EN
      check("rst_is_corner", {31'd0, is_corner}, 32'd0);
`endif
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // all ones: A=B=C=9, R=-20, exactly one output
      base = n_out;
      send_row(ones_c, ones_c, 3, 0, -20, 1'b0);
      drain();
      check("ones_count", 32'(n_out - base), 32'd1);

      // corner row of 4 then slide in ones columns: 108,108,82,39,-20
      send_row(cor_ix, cor_iy, 4, 0, 108, 1'b1);
      send_col(ones_c, ones_c, 1'b0, 1'b1, 82, 1'b0);
      send_col(ones_c, ones_c, 1'b0, 1'b1, 39, 1'b0);
      send_col(ones_c, ones_c, 1'b0, 1'b1, -20, 1'b0);
      drain();

      // positive saturation: R=52992 -> 32767
      send_row(col3(-8, -8, 0), col3(0, 0, -8), 3, 0, 32767, 1'b1);
      // negative saturation: R=-64643 -> -32768
      send_row(col3(-8, -8, -8), col3(7, 7, 7), 3, 0, -32768, 1'b0);
      // mixed signs: A=15 B=-3 C=30 -> R=315
      send_row(col3(2, 1, 0), col3(1, -3, 0), 3, 0, 315, 1'b1);
      // bubbles between columns
      send_row(ones_c, ones_c, 3, 2, -20, 1'b0);
      drain();

      // backpressure: 6 corner columns, 5-cycle stall -> 4 outputs of 108
      base = n_out;
      fork
         begin
            for (int c = 0; c < 6; c++)
               send_col(cor_ix, cor_iy, (c == 0), (c >= 2), 108, 1'b1);
         end
         begin
            bit seen = 1'b0;
            for (int t = 0; t < 60 && !seen; t++) begin
               @(negedge clk);
               if (out_valid) seen = 1'b1;
            end
            if (!seen) begin
               total++;
               bad++;
               $display("FAIL bp_wait actual=no_output required=output");
            end
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("stall_in_ready", {31'd0, in_ready}, 32'd0);
               check("stall_resp", {16'd0, out_resp}, 32'd108);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", 32'(n_out - base), 32'd4);

      // mid-row restart: saturating column must be discarded by the restart
      send_col(col3(-8, -8, 0), col3(0, 0, -8), 1'b1, 1'b0, 0, 1'b0);
      send_col(cor_ix, cor_iy, 1'b1, 1'b0, 0, 1'b0);
      send_col(cor_ix, cor_iy, 1'b0, 1'b0, 0, 1'b0);
      send_col(cor_ix, cor_iy, 1'b0, 1'b1, 108, 1'b1);
      drain();

      // reset with data in flight
      send_row(ones_c, ones_c, 3, 0, -20, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_resp", {16'd0, out_resp}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      base = n_out;
      send_col(cor_ix, cor_iy, 1'b0, 1'b0, 0, 1'b0);
      send_col(cor_ix, cor_iy, 1'b0, 1'b0, 0, 1'b0);
      send_col(cor_ix, cor_iy, 1'b0, 1'b1, 108, 1'b1);
      drain();
      check("midrst_count", 32'(n_out - base), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
